alluvial_issue: RTL and testbench

ALLUVIAL_ISSUE -- requirements
Module: alluvial_issue

---
 rtl/alluvial_issue.sv | 131 +++++++++++++
 tb/tb_alluvial_issue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alluvial_issue.sv
// Command FIFO feeding a combinational ALU, with a registered response stage.
// Optional counters under ALLUVIAL_ISSUE_STATS_EN (stat_ops, stat_errs).
module alluvial_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [31:0] alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_error,
  input  logic [7:0]  alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op,
  output logic [7:0]  out_result,
  output logic        out_error
`ifdef ALLUVIAL_ISSUE_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_errs
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0] op_mem [DEPTH];
  logic [7:0]  a_mem  [DEPTH];
  logic [7:0]  b_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic non_empty;
  logic resp_free;
  logic push;
  logic pop;
  logic [7:0] cap_result;
  logic cap_error;

  assign non_empty = (count != '0);
  assign in_ready  = (count < FULL);
  assign resp_free = !out_valid || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = non_empty && resp_free;

  assign alu_op = non_empty ? op_mem[rd_ptr] : 32'd0;
  assign alu_a  = non_empty ? a_mem[rd_ptr]  : 8'd0;
  assign alu_b  = non_empty ? b_mem[rd_ptr]  : 8'd0;

  // Only ADD reports carry; illegal opcodes ignore the ALU entirely.
  always_comb begin
    cap_result = 8'd0;
    cap_error  = 1'b1;
    case (alu_op)
      32'd0: begin
        cap_result = alu_result;
        cap_error  = alu_error;
      end
      32'd1: begin
        cap_result = alu_result;
        cap_error  = 1'b0;
      end
      default: begin
        cap_result = 8'd0;
        cap_error  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      op_mem[wr_ptr] <= in_op;
      a_mem[wr_ptr]  <= in_a;
      b_mem[wr_ptr]  <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_op     <= 32'd0;
      out_result <= 8'd0;
      out_error  <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_op     <= alu_op;
      out_result <= cap_result;
      out_error  <= cap_error;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ALLUVIAL_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops  <= 16'd0;
      stat_errs <= 16'd0;
    end else if (pop) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (cap_error && stat_errs != 16'hFFFF)
        stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alluvial_issue.sv
// Directed and random checks of alluvial_issue against a queue model.
// Models the downstream ALU and, with ALLUVIAL_ISSUE_STATS_EN, the counters.
module tb_alluvial_issue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_error;
  logic [7:0]  alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op;
  logic [7:0]  out_result;
  logic        out_error;
`ifdef ALLUVIAL_ISSUE_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  always #5 clk = ~clk;

  alluvial_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_a(in_a),
    .in_b(in_b),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_error(alu_error),
    .alu_result(alu_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op(out_op),
    .out_result(out_result),
    .out_error(out_error)
`ifdef ALLUVIAL_ISSUE_STATS_EN
    ,
    .stat_ops(stat_ops),
    .stat_errs(stat_errs)
`endif
  );

  // Downstream ALU; illegal opcodes get junk so the DUT must override it.
  logic [8:0] alu_out;
  always_comb begin
    if (alu_op == 32'd0)
      alu_out = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_op == 32'd1)
      alu_out = {1'b0, alu_a ^ alu_b};
    else
      alu_out = {1'b0, alu_a | alu_b};
  end
  assign alu_error  = alu_out[8];
  assign alu_result = alu_out[7:0];

  typedef struct {
    logic [31:0] op;
    logic [7:0]  a;
    logic [7:0]  b;
  } cmd_t;

  cmd_t        q[$];
  logic        m_valid;
  logic [31:0] m_op;
  logic [7:0]  m_res;
  logic        m_err;
  int          m_ops;
  int          m_errs;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_of(input cmd_t c, output logic [7:0] r,
                                    output logic e);
    logic [8:0] s;
    s = {1'b0, c.a} + {1'b0, c.b};
    if (c.op == 32'd0) begin
      r = s[7:0];
      e = s[8];
    end else if (c.op == 32'd1) begin
      r = c.a ^ c.b;
      e = 1'b0;
    end else begin
      r = 8'h00;
      e = 1'b1;
    end
  endfunction

  task automatic model_edge(input logic r, input logic v, input cmd_t c,
                            input logic ordy);
    bit can_push;
    bit do_pop;
    cmd_t h;
    if (r) begin
      q.delete();
      m_valid = 1'b0;
      m_op = 32'd0;
      m_res = 8'd0;
      m_err = 1'b0;
      m_ops = 0;
      m_errs = 0;
      return;
    end
    can_push = v && (q.size() < DEPTH);
    do_pop = (q.size() != 0) && (!m_valid || ordy);
    if (do_pop) begin
      h = q.pop_front();
      m_valid = 1'b1;
      m_op = h.op;
      expect_of(h, m_res, m_err);
      if (m_ops < 65535) m_ops++;
      if (m_err && m_errs < 65535) m_errs++;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (can_push) q.push_back(c);
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] op,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic ordy);
    cmd_t c;
    c.op = op;
    c.a = a;
    c.b = b;
    rst = r;
    in_valid = v;
    in_op = op;
    in_a = a;
    in_b = b;
    out_ready = ordy;
    @(posedge clk);
    model_edge(r, v, c, ordy);
    #1;
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, m_valid);
    chk("alu_op", alu_op, q.size() != 0 ? q[0].op : 32'd0);
    chk("alu_a", alu_a, q.size() != 0 ? q[0].a : 8'd0);
    if (m_valid) begin
      chk("out_op", out_op, m_op);
      chk("out_result", out_result, m_res);
      chk("out_error", out_error, m_err);
    end
`ifdef ALLUVIAL_ISSUE_STATS_EN
    chk("stat_ops", stat_ops, m_ops);
    chk("stat_errs", stat_errs, m_errs);
`endif
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 32'd0, 8'd0, 8'd0, ordy);
  endtask

  initial begin
    m_valid = 1'b0;
    m_op = 32'd0;
    m_res = 8'd0;
    m_err = 1'b0;
    m_ops = 0;
    m_errs = 0;

    // reset, with a command offered during reset that must be dropped
    step(1'b1, 1'b0, 32'd0, 8'd0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 32'd1, 8'h12, 8'h34, 1'b0);
    chk("rst_out_op", out_op, 32'd0);
    chk("rst_out_result", out_result, 8'd0);
    chk("rst_out_error", out_error, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("rst_no_resp", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);

    // illegal opcode
    step(1'b0, 1'b1, 32'd7, 8'h01, 8'h01, 1'b0);
    idle(1'b0);
    chk("ill_result", out_result, 8'h00);
    chk("ill_error", out_error, 1'b1);
`ifdef ALLUVIAL_ISSUE_STATS_EN
    chk("ill_stat_errs", stat_errs, 16'd1);
`endif
    idle(1'b1);

    // single ADD with carry-out
    step(1'b0, 1'b1, 32'd0, 8'hF0, 8'h20, 1'b0);
    chk("add_lat1", out_valid, 1'b0);
    idle(1'b0);
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", out_result, 8'h10);
    chk("add_error", out_error, 1'b1);
    idle(1'b0);
    chk("add_hold", out_result, 8'h10);
    idle(1'b1);

    // single XOR
    step(1'b0, 1'b1, 32'd1, 8'hAA, 8'hFF, 1'b0);
    idle(1'b0);
    chk("xor_result", out_result, 8'h55);
    chk("xor_error", out_error, 1'b0);
    idle(1'b1);

    // fill with out_ready low: 4 in FIFO plus 1 held in the response
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 32'(i & 1), 8'(8'h10 + i), 8'(i), 1'b0);
    chk("fill_full", in_ready, 1'b0);
    step(1'b0, 1'b1, 32'd0, 8'h99, 8'h99, 1'b0);
    chk("fill_q", q.size(), DEPTH);
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("fill_drained", out_valid, 1'b0);

    // reset mid-operation
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'd0, 8'(i), 8'h01, 1'b0);
    step(1'b1, 1'b0, 32'd0, 8'd0, 8'd0, 1'b1);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("midrst_quiet", out_valid, 1'b0);

    // streaming: 8 back-to-back ADDs
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'd0, 8'(8'h20 * i), 8'(8'h31 + i), 1'b1);
      chk("stream_ready", in_ready, 1'b1);
      if (i > 0) chk("stream_valid", out_valid, 1'b1);
    end
    idle(1'b1);
    chk("stream_last", out_valid, 1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [31:0] op;
      sel = $urandom_range(0, 7);
      op = (sel < 3) ? 32'd0 : (sel < 6) ? 32'd1 : $urandom;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), op,
           8'($urandom), 8'($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("final_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
